// File: rtl/pci_arb_pkg.sv
// Shared types and default constants for the central PCI bus arbiter.
package pci_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        BUSY,
        TURN
    } arb_state_t;

    localparam int unsigned DEF_N_DEV        = 4;
    localparam int unsigned DEF_IDLE_TIMEOUT = 16;
    localparam int unsigned DEF_TMR_W        = 5;

    localparam logic [DEF_N_DEV-1:0] GNT_NONE = '1;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection over active-low requests, scanning upward from ptr.
module rr_picker import pci_arb_pkg::*; #(
    parameter int unsigned N_DEV = DEF_N_DEV,
    parameter int unsigned IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic [N_DEV-1:0] req_n,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    always_comb begin : pick
        logic        found;
        int unsigned idx;
        found  = 1'b0;
        idx    = 0;
        winner = '0;
        for (int unsigned i = 0; i < N_DEV; i++) begin
            idx = (32'(ptr) + i) % N_DEV;
            if (!found && !req_n[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
        any_req = found;
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI arbiter: round-robin grants, hidden arbitration during transactions,
// and revocation of grants that leave the bus idle too long.
module pci_bus_arbiter import pci_arb_pkg::*; #(
    parameter int unsigned N_DEV        = DEF_N_DEV,
    parameter int unsigned IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
    parameter int unsigned TMR_W        = DEF_TMR_W,
    parameter int unsigned IDX_W        = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req,
    output logic [N_DEV-1:0] gnt,
    input  logic             frame,
    input  logic             irdy,
    output logic [IDX_W-1:0] owner,
    output logic             owner_valid,
    output logic             bus_busy
);

    localparam logic [N_DEV-1:0] GNT_ALL = '1;

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] ptr, ptr_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [N_DEV-1:0] gnt_n;
    logic [IDX_W-1:0] owner_n;
    logic             owner_valid_n;

    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             bus_idle;
    logic [N_DEV-1:0] owner_mask;
    logic             owner_req;
    logic             other_req;

    rr_picker #(
        .N_DEV (N_DEV),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_n   (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign bus_idle   = frame & irdy;
    assign owner_mask = N_DEV'(1) << owner;
    assign owner_req  = ~req[owner];
    assign other_req  = |(~req & ~owner_mask);

    // Next-state, grant, timer and round-robin pointer.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        timer_n = timer;
        gnt_n   = gnt;
        owner_n = owner;
        case (state)
            IDLE: begin
                if (any_req) begin
                    owner_n = winner;
                    gnt_n   = ~(N_DEV'(1) << winner);
                    timer_n = '0;
                    state_n = GRANT;
                end else begin
                    gnt_n = GNT_ALL;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_n   = GNT_ALL;
                    state_n = TURN;
                end else if (!frame) begin
                    state_n = BUSY;
                end else if (bus_idle) begin
                    if (timer == TMR_W'(IDLE_TIMEOUT - 1)) begin
                        gnt_n   = GNT_ALL;
                        state_n = TURN;
                    end else begin
                        timer_n = timer + TMR_W'(1);
                    end
                end
            end
            BUSY: begin
                // Hidden arbitration: the owner finishes without its grant.
                if (!owner_req || other_req) begin
                    gnt_n = GNT_ALL;
                end
                if (bus_idle) begin
                    if (gnt_n != GNT_ALL) begin
                        timer_n = '0;
                        state_n = GRANT;
                    end else begin
                        state_n = TURN;
                    end
                end
            end
            TURN: begin
                gnt_n   = GNT_ALL;
                ptr_n   = (owner == IDX_W'(N_DEV - 1)) ? '0 : owner + IDX_W'(1);
                state_n = IDLE;
            end
            default: begin
                gnt_n   = GNT_ALL;
                state_n = IDLE;
            end
        endcase
        owner_valid_n = ((state_n == GRANT) || (state_n == BUSY)) && (gnt_n != GNT_ALL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            timer       <= '0;
            gnt         <= GNT_ALL;
            owner       <= '0;
            owner_valid <= 1'b0;
            bus_busy    <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            timer       <= timer_n;
            gnt         <= gnt_n;
            owner       <= owner_n;
            owner_valid <= owner_valid_n;
            bus_busy    <= ~bus_idle;
        end
    end

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Directed self-checking bench for pci_bus_arbiter.
module tb_pci_bus_arbiter;
    import pci_arb_pkg::*;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       frame;
    logic       irdy;
    logic [1:0] owner;
    logic       owner_valid;
    logic       bus_busy;

    int checks = 0;
    int errors = 0;

    logic [3:0] prev_gnt;
    bit         mon_en = 1'b0;

    pci_bus_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .frame       (frame),
        .irdy        (irdy),
        .owner       (owner),
        .owner_valid (owner_valid),
        .bus_busy    (bus_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [3:0] eg, input logic [1:0] eo,
                             input logic ev);
        check({tag, ".gnt"}, 32'(gnt), 32'(eg));
        check({tag, ".owner"}, 32'(owner), 32'(eo));
        check({tag, ".valid"}, 32'(owner_valid), 32'(ev));
    endtask

    task automatic check_state(input string tag, input arb_state_t es);
        check({tag, ".state"}, 32'(dut.state), 32'(es));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req   = 4'hF;
        frame = 1'b1;
        irdy  = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One 2-cycle transaction by device o while all devices keep requesting.
    task automatic rr_txn(input int o);
        logic [3:0] eg;
        eg = ~(4'b0001 << o);
        frame = 1'b1; irdy = 1'b1;
        tick();
        check_out($sformatf("rr%0d.grant", o), eg, 2'(o), 1'b1);
        frame = 1'b0; irdy = 1'b0;
        tick();
        check_state($sformatf("rr%0d.busy", o), BUSY);
        check($sformatf("rr%0d.busy.gnt", o), 32'(gnt), 32'(eg));
        frame = 1'b1; irdy = 1'b0;
        tick();
        check($sformatf("rr%0d.hidden.gnt", o), 32'(gnt), 32'hF);
        frame = 1'b1; irdy = 1'b1;
        tick();
        check_state($sformatf("rr%0d.turn", o), TURN);
        check($sformatf("rr%0d.turn.gnt", o), 32'(gnt), 32'hF);
        tick();
        check($sformatf("rr%0d.ptr", o), 32'(dut.ptr), 32'((o + 1) % 4));
    endtask

    // Grant exclusivity and the dead cycle between different owners.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert ($countones(~gnt) <= 1) else begin
                errors++;
                $error("FAIL mon.onehot observed=%b expected=at_most_one_low", gnt);
            end
            checks++;
            assert (!(prev_gnt != 4'hF && gnt != 4'hF && gnt != prev_gnt)) else begin
                errors++;
                $error("FAIL mon.handover observed=%b->%b expected=idle_gap", prev_gnt, gnt);
            end
            prev_gnt = gnt;
        end else begin
            prev_gnt = 4'hF;
        end
    end

    initial begin
        // Reset values
        do_reset();
        check_out("rst", GNT_NONE, 2'd0, 1'b0);
        check("rst.busy", 32'(bus_busy), 32'd0);
        check_state("rst", IDLE);
        check("rst.ptr", 32'(dut.ptr), 32'd0);
        mon_en = 1'b1;

        // Basic grant, transaction, release
        req = 4'b1110;
        tick();
        check_out("s1.grant", 4'b1110, 2'd0, 1'b1);
        check_state("s1.grant", GRANT);
        frame = 1'b0;
        tick();
        check_state("s1.busy", BUSY);
        check("s1.bus_busy", 32'(bus_busy), 32'd1);
        frame = 1'b1; irdy = 1'b1; req = 4'b1111;
        tick();
        check_out("s1.turn", 4'hF, 2'd0, 1'b0);
        check_state("s1.turn", TURN);
        check("s1.bus_idle", 32'(bus_busy), 32'd0);
        tick();
        check_state("s1.idle", IDLE);
        check("s1.ptr", 32'(dut.ptr), 32'd1);

        // Round-robin rotation with all requesting
        do_reset();
        req = 4'b0000;
        rr_txn(0);
        rr_txn(1);
        rr_txn(2);
        rr_txn(3);
        rr_txn(0);

        // Idle timeout revokes an unused grant
        do_reset();
        req = 4'b0011;
        tick();
        check_out("to.grant", 4'b1011, 2'd2, 1'b1);
        for (int i = 1; i < 16; i++) begin
            tick();
            check($sformatf("to.hold%0d", i), 32'(gnt), 32'(4'b1011));
        end
        tick();
        check_out("to.revoke", 4'hF, 2'd2, 1'b0);
        check_state("to.revoke", TURN);
        tick();
        check("to.ptr", 32'(dut.ptr), 32'd3);
        tick();
        check_out("to.next", 4'b0111, 2'd3, 1'b1);

        // Hidden arbitration while device 1 is busy
        do_reset();
        req = 4'b1101;
        tick();
        check_out("ha.grant", 4'b1101, 2'd1, 1'b1);
        frame = 1'b0; irdy = 1'b0;
        tick();
        tick();
        check("ha.busy.gnt", 32'(gnt), 32'(4'b1101));
        req = 4'b0101;
        tick();
        check_out("ha.drop", 4'hF, 2'd1, 1'b0);
        check_state("ha.drop", BUSY);
        tick();
        check("ha.still", 32'(gnt), 32'hF);
        frame = 1'b1; irdy = 1'b1;
        tick();
        check_state("ha.turn", TURN);
        check("ha.turn.gnt", 32'(gnt), 32'hF);
        tick();
        check("ha.idle.gnt", 32'(gnt), 32'hF);
        tick();
        check_out("ha.next", 4'b0111, 2'd3, 1'b1);

        // Lone requester back-to-back, no TURN
        do_reset();
        req = 4'b1110;
        tick();
        frame = 1'b0; irdy = 1'b0;
        tick();
        check_state("b2b.busy", BUSY);
        frame = 1'b1; irdy = 1'b1;
        tick();
        check_out("b2b.park", 4'b1110, 2'd0, 1'b1);
        check_state("b2b.park", GRANT);
        frame = 1'b0;
        tick();
        check_state("b2b.busy2", BUSY);
        check("b2b.busy2.gnt", 32'(gnt), 32'(4'b1110));

        // Request withdrawn the cycle it is picked
        do_reset();
        req = 4'b1110;
        tick();
        req = 4'b1111;
        check("wd.grant", 32'(gnt), 32'(4'b1110));
        tick();
        check_state("wd.turn", TURN);
        check("wd.turn.gnt", 32'(gnt), 32'hF);

        // Reset during BUSY
        do_reset();
        req = 4'b1011;
        tick();
        frame = 1'b0; irdy = 1'b0;
        tick();
        check("mr.busy.gnt", 32'(gnt), 32'(4'b1011));
        check_state("mr.busy", BUSY);
        rst = 1'b1;
        tick();
        check_out("mr.rst", 4'hF, 2'd0, 1'b0);
        check("mr.bus_busy", 32'(bus_busy), 32'd0);
        rst = 1'b0;
        frame = 1'b1; irdy = 1'b1; req = 4'hF;
        tick();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
